// File: rtl/bram_tdp_cascade.sv
// True dual-port RAM built from two half-depth banks selected by the address MSB.
// Each port owns its own storage array, so every array has exactly one writer
// and one clock. The logical word is the XOR of both arrays: a port stores
// (din ^ peer_word), which makes a read of (own ^ peer) return din.
// When both ports write the same word in one cycle, port A backs off so that
// port B's data is the one stored.
module bram_tdp_cascade #(
    parameter int DW = 36,
    parameter int AW = 12
) (
    input  logic          clkA,
    input  logic          clkB,
    input  logic          rstA,
    input  logic          rstB,
    input  logic          enA,
    input  logic          enB,
    input  logic          weA,
    input  logic          weB,
    input  logic [AW-1:0] addrA,
    input  logic [AW-1:0] addrB,
    input  logic [DW-1:0] dinA,
    input  logic [DW-1:0] dinB,
    output logic [DW-1:0] doutA,
    output logic [DW-1:0] doutB
);
    localparam int BW   = AW - 1;
    localparam int HALF = 2 ** BW;

    // Storage: [bank][word within bank], one array per port
    logic [DW-1:0] memA_q [2][HALF];
    logic [DW-1:0] memB_q [2][HALF];

    logic          selA, selB;
    logic [BW-1:0] baA, baB;
    logic          wrA, wrB;

    // Stage 1: both banks' words plus the bank select that picks between them
    logic [1:0][DW-1:0] rdA_d, rdB_d;
    logic [1:0][DW-1:0] bankA_q, bankB_q;
    logic               bselA_q, bselB_q;

    // Stage 2: output registers
    logic [DW-1:0] doutA_q, doutB_q;

    assign selA = addrA[AW-1];
    assign selB = addrB[AW-1];
    assign baA  = addrA[AW-2:0];
    assign baB  = addrB[AW-2:0];

    // Port B wins a same-word double write, so port A suppresses its write then
    assign wrB = enB & weB;
    assign wrA = enA & weA & ~(wrB & (addrA == addrB));

    // Bank read data per port: old contents across ports, own write data forwarded
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            rdA_d[b] = memA_q[b][baA] ^ memB_q[b][baA];
            rdB_d[b] = memA_q[b][baB] ^ memB_q[b][baB];
            if (weA && (selA == 1'(b))) rdA_d[b] = dinA;
            if (weB && (selB == 1'(b))) rdB_d[b] = dinB;
        end
    end

    // Port A array write; stored word is encoded against port B's array
    always_ff @(posedge clkA) begin
        if (wrA) memA_q[selA][baA] <= dinA ^ memB_q[selA][baA];
    end

    // Port B array write; stored word is encoded against port A's array
    always_ff @(posedge clkB) begin
        if (wrB) memB_q[selB][baB] <= dinB ^ memA_q[selB][baB];
    end

    // Port A stage 1: latch bank data with its select so they stay paired
    always_ff @(posedge clkA) begin
        if (rstA) begin
            bankA_q <= '0;
            bselA_q <= 1'b0;
        end else if (enA) begin
            bankA_q <= rdA_d;
            bselA_q <= selA;
        end
    end

    // Port A stage 2: cascade mux registered every cycle
    always_ff @(posedge clkA) begin
        if (rstA) doutA_q <= '0;
        else      doutA_q <= bankA_q[bselA_q];
    end

    // Port B stage 1: latch bank data with its select so they stay paired
    always_ff @(posedge clkB) begin
        if (rstB) begin
            bankB_q <= '0;
            bselB_q <= 1'b0;
        end else if (enB) begin
            bankB_q <= rdB_d;
            bselB_q <= selB;
        end
    end

    // Port B stage 2: cascade mux registered every cycle
    always_ff @(posedge clkB) begin
        if (rstB) doutB_q <= '0;
        else      doutB_q <= bankB_q[bselB_q];
    end

    assign doutA = doutA_q;
    assign doutB = doutB_q;

endmodule

// File: tb/tb_bram_tdp_cascade.sv
// Bench for bram_tdp_cascade: both ports on one clock, a word-level memory
// model with a two-cycle read pipeline, and literal expectations per scenario.
module tb_bram_tdp_cascade;
    localparam int DW = 36;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rstA, rstB, enA, enB, weA, weB;
    logic [AW-1:0] addrA, addrB;
    logic [DW-1:0] dinA, dinB;
    logic [DW-1:0] doutA, doutB;

    bram_tdp_cascade #(.DW(DW), .AW(AW)) dut (
        .clkA(clk), .clkB(clk), .rstA(rstA), .rstB(rstB),
        .enA(enA), .enB(enB), .weA(weA), .weB(weB),
        .addrA(addrA), .addrB(addrB), .dinA(dinA), .dinB(dinB),
        .doutA(doutA), .doutB(doutB)
    );

    always #5 clk = ~clk;

    // Model: flat word array, "value read at edge k shows at dout after edge k+1"
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] pendA, pendB, expA, expB, rdA, rdB;
    bit            chk_on = 1'b0;

    // Literal expectations, checked by the compare process at the next negedge
    bit            litA_en = 1'b0, litB_en = 1'b0;
    logic [DW-1:0] litA_v, litB_v;
    int            lit_tag = 0;

    int total = 0;
    int bad   = 0;

    initial begin
        for (int i = 0; i < 2**AW; i++) mem[i] = '0;
        pendA = '0; pendB = '0; expA = '0; expB = '0;
    end

    // Model update on every edge: read (write-first per port, old data across ports), then write
    always @(posedge clk) begin
        rdA = (enA && weA) ? dinA : mem[addrA];
        rdB = (enB && weB) ? dinB : mem[addrB];
        if (rstA) begin expA = '0; pendA = '0; end
        else begin expA = pendA; if (enA) pendA = rdA; end
        if (rstB) begin expB = '0; pendB = '0; end
        else begin expB = pendB; if (enB) pendB = rdB; end
        if (enA && weA) mem[addrA] = dinA;
        if (enB && weB) mem[addrB] = dinB;
    end

    // Compare process: model every cycle, plus any pending literal expectation
    always @(negedge clk) begin
        if (chk_on) begin
            total++;
            if (doutA !== expA) begin
                bad++;
                $display("FAIL model_A t=%0t got=%h want=%h", $time, doutA, expA);
            end
            total++;
            if (doutB !== expB) begin
                bad++;
                $display("FAIL model_B t=%0t got=%h want=%h", $time, doutB, expB);
            end
        end
        if (litA_en) begin
            total++;
            if (doutA !== litA_v) begin
                bad++;
                $display("FAIL lit_A tag=%0d got=%h want=%h", lit_tag, doutA, litA_v);
            end
        end
        if (litB_en) begin
            total++;
            if (doutB !== litB_v) begin
                bad++;
                $display("FAIL lit_B tag=%0d got=%h want=%h", lit_tag, doutB, litB_v);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        litA_en = 1'b0;
        litB_en = 1'b0;
    endtask

    task automatic litA(input int tag, input logic [DW-1:0] v);
        lit_tag = tag; litA_v = v; litA_en = 1'b1;
    endtask

    task automatic litB(input int tag, input logic [DW-1:0] v);
        lit_tag = tag; litB_v = v; litB_en = 1'b1;
    endtask

    task automatic portA(input logic en, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        enA = en; weA = we; addrA = a; dinA = d;
    endtask

    task automatic portB(input logic en, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        enB = en; weB = we; addrB = a; dinB = d;
    endtask

    initial begin
        rstA = 1'b1; rstB = 1'b1;
        portA(0, 0, '0, '0);
        portB(0, 0, '0, '0);

        // 1. Reset held three cycles, then idle after release
        step(); chk_on = 1'b1;
        step(); step();
        litA(1, '0); litB(1, '0);
        rstA = 1'b0; rstB = 1'b0;
        step(); step();
        litA(2, '0); litB(2, '0);

        // 2. Ping-pong: addresses inverted each cycle, data swapped
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                portA(1, 1, 12'h5A5, 36'h000000000);
                portB(1, 1, 12'hA5A, 36'hFFFFFFFFF);
            end else begin
                portA(1, 1, 12'hA5A, 36'hFFFFFFFFF);
                portB(1, 1, 12'h5A5, 36'h000000000);
            end
            step();
            if (i >= 1) begin
                litA(10 + i, ((i - 1) % 2 == 0) ? 36'h000000000 : 36'hFFFFFFFFF);
                litB(10 + i, ((i - 1) % 2 == 0) ? 36'hFFFFFFFFF : 36'h000000000);
            end
        end
        portA(0, 0, '0, '0);
        portB(0, 0, '0, '0);
        step();

        // 3. Latency: write 0x001, flush with a read of 0x002, then read 0x001
        portA(1, 1, 12'h001, 36'h123456789); step();
        portA(1, 0, 12'h002, '0);            step();
        portA(1, 0, 12'h001, '0);            step();
        litA(30, 36'h000000000);
        portA(0, 0, 12'h001, '0);            step();
        litA(31, 36'h123456789);

        // 4. Cascade boundary: write via B, read back to back via A
        portB(1, 1, 12'h7FF, 36'h0AAAAAAAA); step();
        portB(1, 1, 12'h800, 36'h155555555); step();
        portB(0, 0, '0, '0);
        portA(1, 0, 12'h7FF, '0);            step();
        portA(1, 0, 12'h800, '0);            step();
        litA(40, 36'h0AAAAAAAA);
        portA(0, 0, 12'h7FF, '0);            step();
        litA(41, 36'h155555555);
        step();
        litA(42, 36'h155555555);

        // 5. Collisions at 0x800
        portA(1, 1, 12'h800, 36'h1);
        portB(1, 1, 12'h800, 36'h2);         step();
        portB(0, 0, '0, '0);
        portA(1, 0, 12'h800, '0);            step();
        portA(0, 0, '0, '0);                 step();
        litA(50, 36'h2);
        portA(1, 0, 12'h800, '0);
        portB(1, 1, 12'h800, 36'h3);         step();
        portA(0, 0, '0, '0);
        portB(0, 0, '0, '0);                 step();
        litA(51, 36'h2);
        portA(1, 0, 12'h800, '0);            step();
        portA(0, 0, '0, '0);                 step();
        litA(52, 36'h3);

        // 6. Enable hold with weA=1 and a moving address
        portB(1, 1, 12'h5A5, 36'h0DEADBEEF); step();
        portB(0, 0, '0, '0);
        portA(1, 0, 12'h5A5, '0);            step();
        portA(0, 1, 12'h5A5, 36'h111111111); step(); litA(60, 36'h0DEADBEEF);
        portA(0, 1, 12'h000, 36'h111111111); step(); litA(61, 36'h0DEADBEEF);
        portA(0, 1, 12'h7FF, 36'h111111111); step(); litA(62, 36'h0DEADBEEF);
        portA(0, 1, 12'h800, 36'h111111111); step(); litA(63, 36'h0DEADBEEF);
        portA(1, 0, 12'h5A5, '0);            step();
        portA(1, 0, 12'h000, '0);            step(); litA(64, 36'h0DEADBEEF);
        portA(1, 0, 12'h7FF, '0);            step(); litA(65, 36'h000000000);
        portA(1, 0, 12'h800, '0);            step(); litA(66, 36'h0AAAAAAAA);
        portA(0, 0, '0, '0);                 step(); litA(67, 36'h3);

        // Mid-operation reset on A discards the in-flight read; B keeps reading
        portB(1, 0, 12'hA5A, '0);
        portA(1, 0, 12'h7FF, '0);            step();
        rstA = 1'b1;
        portA(1, 0, 12'h800, '0);            step();
        litA(70, '0);
        rstA = 1'b0;
        portA(0, 0, '0, '0);                 step();
        litA(71, '0); litB(71, 36'hFFFFFFFFF);
        portB(0, 0, '0, '0);                 step();
        litA(72, '0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
